// File: rtl/spi_rx_master.sv
// spi_rx_master: read-only SPI master (mode 0, MSB first) with an optional frame check (SPI_FRAME_CHECK_EN)
module spi_rx_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ena,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic              spi_not_busy,
  output logic [DATA_W-1:0] spi_rx_data
`ifdef SPI_FRAME_CHECK_EN
  ,
  output logic              frame_err
`endif
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [DATA_W-1:0] sh, sh_n, rx_n;
  logic sclk_n, cs_n_n, nb_n, last;
  assign last = cnt == CW'(CLK_DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    bits_n = bits;
    sh_n = sh;
    rx_n = spi_rx_data;
    sclk_n = sclk;
    cs_n_n = cs_n;
    nb_n = spi_not_busy;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bits_n = '0;
        if (spi_ena) begin
          state_n = SETUP;
          cs_n_n = 1'b0;
          nb_n = 1'b0;
        end
      end
      SETUP: state_n = last ? SHIFT : SETUP;
      SHIFT: if (last) begin
        sclk_n = !sclk;
        if (!sclk) begin
          sh_n = {sh[DATA_W-2:0], miso};
          bits_n = bits + 1'b1;
        end else if (bits == BW'(DATA_W)) state_n = HOLD;
      end
      HOLD: if (last) begin
        state_n = GAP;
        cs_n_n = 1'b1;
        rx_n = sh;
      end
      GAP: if (last) begin
        state_n = IDLE;
        nb_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      sh <= '0;
      sclk <= 1'b0;
      cs_n <= 1'b1;
      spi_not_busy <= 1'b1;
      spi_rx_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      sh <= sh_n;
      sclk <= sclk_n;
      cs_n <= cs_n_n;
      spi_not_busy <= nb_n;
      spi_rx_data <= rx_n;
    end
  end
`ifdef SPI_FRAME_CHECK_EN
  localparam logic [DATA_W-1:0] RSV = (DATA_W == 32) ? DATA_W'(64'h2_0008) : '0;
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else if (state == HOLD && last) frame_err <= (&sh) | (|(sh & RSV));
  end
`endif
endmodule

// File: tb/tb_spi_rx_master.sv
// tb_spi_rx_master: randomized bench with a timeline model of the SPI read master
module tb_spi_rx_master;
  localparam int C = 4, D = 32, B = (2*D+3)*C, CAP = (2*D+2)*C+1, SH_END = C+2*D*C;
  logic clk = 0, rst = 1, ena = 0, miso = 0;
  logic sclk, cs_n, nb;
  logic [D-1:0] rx;
  logic e2 = 0, m2 = 0, s2, cs2, nb2;
  logic [7:0] rx2;
`ifdef SPI_FRAME_CHECK_EN
  logic err, err2;
  logic exp_err = 0;
`endif
  always #5 clk = ~clk;
  spi_rx_master #(.CLK_DIV(C), .DATA_W(D)) dut (
    .clk(clk), .rst(rst), .spi_ena(ena), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .spi_not_busy(nb), .spi_rx_data(rx)
`ifdef SPI_FRAME_CHECK_EN
    , .frame_err(err)
`endif
  );
  spi_rx_master #(.CLK_DIV(1), .DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .spi_ena(e2), .miso(m2), .sclk(s2), .cs_n(cs2),
    .spi_not_busy(nb2), .spi_rx_data(rx2)
`ifdef SPI_FRAME_CHECK_EN
    , .frame_err(err2)
`endif
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // o = cycles since the request was accepted (0 = idle); outputs follow directly from o
  int o = 0, frames = 0, accepts = 0;
  logic [D-1:0] cur = '0, exp_rx = '0;
  logic [D-1:0] q[$];
  logic [D-1:0] rx_log[$];
  int rises = 0, last_rises = 0, busy_run = 0, last_busy = 0;
  int cs_hi_run = 0, last_cs_hi = 0, nb_hi_run = 0, last_nb_hi = 0;
  bit prev_sclk = 0;
  function automatic bit m_sclk(int t);
    if (t <= C || t > SH_END) return 1'b0;
    return ((t-1-C)/C) % 2 == 1;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      o = 0;
      exp_rx = '0;
`ifdef SPI_FRAME_CHECK_EN
      exp_err = 0;
`endif
    end else if (o == 0) begin
      if (ena) begin
        o = 1;
        accepts++;
        rises = 0;
        cur = q.size() > 0 ? q.pop_front() : D'($urandom);
      end
    end else o = (o == B) ? 0 : o + 1;
    if (o == CAP) begin
      exp_rx = cur;
      frames++;
      rx_log.push_back(cur);
      last_rises = rises;
`ifdef SPI_FRAME_CHECK_EN
      exp_err = (&cur) | (cur[17] | cur[3]);
`endif
    end
    #1;
    chk("cyc_not_busy", nb, o == 0);
    chk("cyc_cs_n", cs_n, !(o >= 1 && o <= CAP-1));
    chk("cyc_sclk", sclk, m_sclk(o));
    chk("cyc_rx_data", rx, exp_rx);
`ifdef SPI_FRAME_CHECK_EN
    chk("cyc_frame_err", err, exp_err);
`endif
    if (sclk && !prev_sclk) rises++;
    prev_sclk = sclk;
    if (!nb) busy_run++;
    else begin
      if (busy_run > 0) last_busy = busy_run;
      busy_run = 0;
    end
    if (nb) nb_hi_run++;
    else begin
      if (nb_hi_run > 0) last_nb_hi = nb_hi_run;
      nb_hi_run = 0;
    end
    if (cs_n) cs_hi_run++;
    else begin
      if (cs_hi_run > 0) last_cs_hi = cs_hi_run;
      cs_hi_run = 0;
    end
    // Drive the bit due at the next rising edge only during low halves; noise elsewhere
    if (o > C && o <= SH_END && ((o-1-C)/C) % 2 == 0) miso = cur[D-1-(o-1-C)/C/2];
    else miso = 1'($urandom);
  end
  task automatic pulse();
    @(negedge clk) ena = 1;
    @(negedge clk) ena = 0;
  endtask
  task automatic wait_frames(int target);
    int t = 0;
    while (frames < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", frames >= target, 1);
  endtask
  task automatic run_frame(logic [D-1:0] d, string name);
    int f0 = frames;
    q.push_back(d);
    pulse();
    wait_frames(f0 + 1);
    repeat (C+2) @(negedge clk);
    chk(name, rx, d);
  endtask
  initial begin
    int base, acc0, t;
    logic [D-1:0] d;
    logic [7:0] d8;
    int busy2, r2, last_rise, per_bad;
    bit ps;
    repeat (3) @(negedge clk);
    chk("rst_not_busy", nb, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_rx", rx, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    run_frame(32'hA5C3_0F10, "t1_rx");
    chk("t1_rises", last_rises, 32);
    chk("t1_busy", last_busy, 268);
    base = frames;
    acc0 = accepts;
    q.push_back(32'd1);
    q.push_back(32'd2);
    q.push_back(32'd3);
    @(negedge clk) ena = 1;
    wait_frames(base + 3);
    ena = 0;
    repeat (C+2) @(negedge clk);
    chk("b2b_accepts", accepts - acc0, 3);
    chk("b2b_rx0", rx_log[rx_log.size()-3], 1);
    chk("b2b_rx1", rx_log[rx_log.size()-2], 2);
    chk("b2b_rx2", rx_log[rx_log.size()-1], 3);
    chk("b2b_cs_high", last_cs_hi, 5);
    chk("b2b_nb_pulse", last_nb_hi, 1);
    acc0 = accepts;
    base = frames;
    q.push_back(32'h0F0F_3C3C);
    pulse();
    repeat (100) @(negedge clk);
    pulse();
    wait_frames(base + 1);
    repeat (20) @(negedge clk);
    chk("ign_accepts", accepts - acc0, 1);
    chk("ign_busy", last_busy, 268);
    chk("ign_rx", rx, 32'h0F0F_3C3C);
    pulse();
    t = 0;
    while (rises < 10 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst10_reached", rises, 10);
    rst = 1;
    @(negedge clk);
    chk("rst10_cs_n", cs_n, 1);
    chk("rst10_sclk", sclk, 0);
    chk("rst10_nb", nb, 1);
    chk("rst10_rx", rx, 0);
    rst = 0;
    @(negedge clk);
    run_frame(32'h3D6B_91E2, "rst10_next_rx");
    chk("rst10_next_rises", last_rises, 32);
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? '1 : D'($urandom);
      base = frames;
      q.push_back(d);
      pulse();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 200)) @(negedge clk);
        pulse();
      end
      wait_frames(base + 1);
      repeat (C+2+$urandom_range(0, 5)) @(negedge clk);
      chk("rand_rx", rx, d);
    end
`ifdef SPI_FRAME_CHECK_EN
    run_frame(32'hFFFF_FFFF, "fc_ones_rx");
    chk("fc_ones_err", err, 1);
    run_frame(32'h0000_0008, "fc_bit3_rx");
    chk("fc_bit3_err", err, 1);
    run_frame(32'h1234_0000, "fc_ok_rx");
    chk("fc_ok_err", err, 0);
`endif
    d8 = 8'h81;
    busy2 = 0;
    r2 = 0;
    last_rise = -1;
    per_bad = 0;
    ps = 0;
    @(negedge clk) begin
      e2 = 1;
      m2 = d8[7];
    end
    @(negedge clk) e2 = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (!nb2) busy2++;
      else if (busy2 > 0) break;
      if (s2 && !ps) begin
        r2++;
        if (last_rise >= 0 && cyc - last_rise != 2) per_bad++;
        last_rise = cyc;
      end
      ps = s2;
      m2 = r2 < 8 ? d8[7-r2] : 1'b0;
      @(negedge clk);
    end
    chk("d8_busy", busy2, 19);
    chk("d8_rises", r2, 8);
    chk("d8_period", per_bad, 0);
    chk("d8_rx", rx2, 8'h81);
`ifdef SPI_FRAME_CHECK_EN
    chk("d8_err", err2, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
